muldiv_sequencer: RTL and testbench

// - Iterative RV32M multiply/divide unit, sequenced by a small FSM; sits beside the ALU in execute.
// - Decode raises start for op=0110011 with funct7=0000001. Operands come from RD1/RD2; result goes to the

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// funct3 decodes directly into md_op_t; the helpers classify each op's operand signedness.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic op_is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input md_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MULHSU treats rs1 as signed and rs2 as unsigned.
  function automatic logic op_a_signed(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath on {acc_hi, acc_lo}: a radix-2 shift-add
// for multiply, or one restoring shift-subtract (one quotient bit) for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_hi_nxt,
  output logic [XLEN-1:0] acc_lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Multiply: acc_lo holds the remaining multiplier bits; the product shifts in from the top.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  always_comb begin
    acc_hi_nxt = '0;
    acc_lo_nxt = '0;
    sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted    = {acc_hi, acc_lo[XLEN-1]};
    diff       = shifted[XLEN-1:0] - operand;

    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        acc_hi_nxt = diff;
        acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        acc_hi_nxt = shifted[XLEN-1:0];
        acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_hi_nxt = sum[XLEN:1];
      acc_lo_nxt = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU: XLEN iterations on operand
// magnitudes, then one sign-fix cycle. Divide-by-zero and signed overflow bypass the iterations.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW        = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;
  logic            neg_r_q, neg_r_d;

  md_op_t          req_op;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;
  logic            idle_like, accept;

  logic            step_is_div;
  logic [XLEN-1:0] step_hi, step_lo;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_value;

  always_comb begin
    req_op       = md_op_t'(funct3);
    sign_a       = op_a_signed(req_op) & op_a[XLEN-1];
    sign_b       = op_b_signed(req_op) & op_b[XLEN-1];
    mag_a        = sign_a ? -op_a : op_a;
    mag_b        = sign_b ? -op_b : op_b;
    div_by_zero  = op_is_div(req_op) && (op_b == '0);
    div_overflow = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (op_a == MOST_NEG) && (op_b == '1);
    idle_like    = (state_q == IDLE) || (state_q == DONE);
    accept       = start && !flush && idle_like;
    busy         = (state_q == CALC) || (state_q == FIX);
    stall        = (start && idle_like) || busy;
    done         = (state_q == DONE);
    result       = result_q;
    step_is_div  = op_is_div(op_q);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div     (step_is_div),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .operand    (opnd_q),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  // neg_q flags product/quotient negation; neg_r_q flags remainder negation (follows dividend).
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    case (op_q)
      OP_MUL:                       fix_value = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_value = quot_fix;
      OP_REM, OP_REMU:              fix_value = rem_fix;
      default:                      fix_value = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_d    = req_op;
            count_d = '0;
            neg_d   = sign_a ^ sign_b;
            neg_r_d = sign_a;
            if (div_by_zero) begin
              result_d = op_is_rem(req_op) ? op_a : '1;
              state_d  = DONE;
            end else if (div_overflow) begin
              result_d = (req_op == OP_REM) ? '0 : op_a;
              state_d  = DONE;
            end else begin
              acc_hi_d = '0;
              acc_lo_d = op_is_div(req_op) ? mag_a : mag_b;
              opnd_d   = op_is_div(req_op) ? mag_b : mag_a;
              state_d  = CALC;
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_ITER) state_d = FIX;
        end
        FIX: begin
          result_d = fix_value;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed RV32M cases, control corner cases and
// randomized operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit signed/unsigned arithmetic following the RV32M rules.
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64s, p;
    logic [63:0]        up;
    int                 sa, sb, q;
    sa64  = {{32{a[31]}}, a};
    sb64  = {{32{b[31]}}, b};
    ub64s = {32'b0, b};
    sa    = a;
    sb    = b;
    case (f)
      3'd0: begin p = sa64 * sb64; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64s; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one op (at the next falling edge, or immediately when now=1) and waits for done.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input bit now, output int lat, output bit busy_seen,
                               output bit stall_ok);
    if (!now) @(negedge clk);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    stall_ok  = (stall === 1'b1);
    busy_seen = 1'b0;
    lat       = 0;
    while (lat < 60) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) begin
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
      #1;
      if (done === 1'b1) begin
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (busy === 1'b1) busy_seen = 1'b1;
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  logic [2:0]  dir_f [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] dir_a [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          dir_lat [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

  initial begin
    int          lat;
    bit          busy_seen;
    bit          stall_ok;
    bit          saw_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    op_a   = '0;
    op_b   = '0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(dir_f[i], dir_a[i], dir_b[i], 1'b0, lat, busy_seen, stall_ok);
      checkOutput($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir_lat[i]));
      checkOutput($sformatf("dir%0d_result", i), result, dir_exp[i]);
      checkOutput($sformatf("dir%0d_stall", i), 32'(stall_ok), 32'd1);
      if (dir_lat[i] == 1) checkOutput($sformatf("dir%0d_busy_never", i), 32'(busy_seen), 32'd0);
    end

    @(negedge clk);
    #1;
    checkOutput("done_single_cycle", 32'(done), 32'd0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    applyStimulus(3'd5, 32'd100, 32'd7, 1'b0, lat, busy_seen, stall_ok);
    checkOutput("b2b_first_result", result, 32'd14);
    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, lat, busy_seen, stall_ok);
    checkOutput("b2b_second_latency", 32'(lat), 32'd34);
    checkOutput("b2b_second_result", result, 32'hFFFF_FFEB);

    // A start pulse while CALC is running must be ignored.
    @(negedge clk);
    funct3 = 3'd5;
    op_a   = 32'd1000;
    op_b   = 32'd10;
    start  = 1'b1;
    lat    = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd3;
        op_b   = 32'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done === 1'b1) break;
    end
    checkOutput("ignore_start_latency", 32'(lat), 32'd34);
    checkOutput("ignore_start_result", result, 32'd100);

    // Flush at cycle 10 of a DIV: back to IDLE, no done, result kept.
    @(negedge clk);
    funct3   = 3'd4;
    op_a     = 32'hFFFF_FFF9;
    op_b     = 32'd2;
    start    = 1'b1;
    saw_done = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (c == 10);
      #1;
      if (c == 5) checkOutput("flush_busy_before", 32'(busy), 32'd1);
      if (c == 11) checkOutput("flush_idle_busy", 32'(busy), 32'd0);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("flush_no_done", 32'(saw_done), 32'd0);
    checkOutput("flush_result_kept", result, 32'd100);

    // flush and start together: flush wins.
    @(negedge clk);
    funct3   = 3'd0;
    op_a     = 32'd9;
    op_b     = 32'd9;
    start    = 1'b1;
    flush    = 1'b1;
    saw_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      if (c == 1) checkOutput("flush_start_busy", 32'(busy), 32'd0);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("flush_start_no_done", 32'(saw_done), 32'd0);
    checkOutput("flush_start_result", result, 32'd100);

    // Asynchronous reset at cycle 5 of a MUL.
    @(negedge clk);
    funct3 = 3'd0;
    op_a   = 32'd5;
    op_b   = 32'd6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_done", 32'(done), 32'd0);
    checkOutput("rst_async_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, busy_seen, stall_ok);
    checkOutput("post_rst_latency", 32'(lat), 32'd34);
    checkOutput("post_rst_result", result, 32'hFFFF_FFEB);

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      applyStimulus(rf, ra, rb, 1'b0, lat, busy_seen, stall_ok);
      checkOutput($sformatf("rand%0d_f%0d_latency", i, rf), 32'(lat), 32'(refLatency(rf, ra, rb)));
      checkOutput($sformatf("rand%0d_f%0d_a%08h_b%08h", i, rf, ra, rb), result, refResult(rf, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
